// File: rtl/sm_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial sign-magnitude adder.
// Holds the FSM state encoding and sign/magnitude field accessors.
package sm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sm_add_state_t;

  // Widest operand the field helpers handle. Callers zero-extend into this.
  localparam int unsigned SM_MAX_W = 64;

  // Sign bit of an n-bit sign-magnitude word (bit n-1).
  function automatic logic get_sign(input logic [SM_MAX_W-1:0] v,
                                    input int unsigned         n);
    logic [SM_MAX_W-1:0] t;
    t = v >> (n - 1);
    return t[0];
  endfunction

  // Magnitude field of an n-bit sign-magnitude word (bits n-2:0), zero-extended.
  function automatic logic [SM_MAX_W-1:0] get_mag(input logic [SM_MAX_W-1:0] v,
                                                  input int unsigned         n);
    logic [SM_MAX_W-1:0] mask;
    mask = (SM_MAX_W'(1) << (n - 1)) - SM_MAX_W'(1);
    return v & mask;
  endfunction

endpackage

// File: rtl/sm_serial_bit_alu.sv
// One-bit add/subtract cell for bit-serial arithmetic.
// sub=0: full adder (r = x^y^cin, cout = majority).
// sub=1: full subtractor x - y - cin (cout is the outgoing borrow).
// Purely combinational so other serial datapaths can reuse it.
module sm_serial_bit_alu (
  input  logic i_x,
  input  logic i_y,
  input  logic i_sub,
  input  logic i_cin,
  output logic o_r,
  output logic o_cout
);

  logic w_carry;
  logic w_borrow;

  assign w_carry  = (i_x & i_y) | (i_x & i_cin) | (i_y & i_cin);
  assign w_borrow = (~i_x & i_y) | (~(i_x ^ i_y) & i_cin);

  assign o_r    = i_x ^ i_y ^ i_cin;
  assign o_cout = i_sub ? w_borrow : w_carry;

endmodule

// File: rtl/sm_serial_adder.sv
// Bit-serial sign-magnitude adder: o_out = in_a + in_b, one magnitude bit
// per clock, LSB first, with valid/ready handshakes on both sides.
// Operands are ordered at capture so that an effective subtraction always
// computes larger - smaller, which keeps the final borrow at zero.
// Optional build macro: SM_ADD_SATURATE_EN -- clamp the magnitude to
// all-ones on add overflow instead of wrapping (o_carry still reports it).
module sm_serial_adder
  import sm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_valid,
  output logic         o_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         o_valid,
  input  logic         in_ready,
  output logic [N-1:0] o_out,
  output logic         o_carry
);

  localparam int MAG_W = N - 1;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 2);

  // Operand field split
  logic             w_sign_a;
  logic             w_sign_b;
  logic [MAG_W-1:0] w_mag_a;
  logic [MAG_W-1:0] w_mag_b;

  assign w_sign_a = get_sign(SM_MAX_W'(in_a), N);
  assign w_sign_b = get_sign(SM_MAX_W'(in_b), N);
  assign w_mag_a  = MAG_W'(get_mag(SM_MAX_W'(in_a), N));
  assign w_mag_b  = MAG_W'(get_mag(SM_MAX_W'(in_b), N));

  // State and datapath registers
  sm_add_state_t    r_state;
  logic [MAG_W-1:0] r_x;
  logic [MAG_W-1:0] r_y;
  logic [MAG_W-1:0] r_mag;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sub;
  logic             r_res_sign;
  logic             r_cy;
  logic             r_ready;
  logic             r_valid;
  logic [N-1:0]     r_out;
  logic             r_carry;

  // Capture-time operand ordering
  logic             w_sub;
  logic [MAG_W-1:0] w_cap_x;
  logic [MAG_W-1:0] w_cap_y;
  logic             w_cap_sign;

  // Serial cell and result assembly
  logic             w_r;
  logic             w_cout;
  logic             w_last;
  logic [MAG_W-1:0] w_mag_shift;
  logic [MAG_W-1:0] w_final_mag;

  // Choose X/Y and result sign so a subtraction is always larger - smaller.
  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sub      = w_sign_a ^ w_sign_b;
    w_cap_x    = w_mag_a;
    w_cap_y    = w_mag_b;
    w_cap_sign = w_sign_a;
    if (w_sub) begin
      if (w_mag_b > w_mag_a) begin
        w_cap_x    = w_mag_b;
        w_cap_y    = w_mag_a;
        w_cap_sign = w_sign_b;
      end else if (w_mag_a == w_mag_b) begin
        w_cap_y    = w_mag_a;
        w_cap_sign = 1'b0;
      end
    end
  end

  sm_serial_bit_alu u_bit_alu (
    .i_x    (r_x[0]),
    .i_y    (r_y[0]),
    .i_sub  (r_sub),
    .i_cin  (r_cy),
    .o_r    (w_r),
    .o_cout (w_cout)
  );

  // Each new result bit enters at the top; after MAG_W shifts bit 0 is in place.
  assign w_mag_shift = (r_mag >> 1) | (MAG_W'(w_r) << (MAG_W - 1));
  assign w_last      = (r_cnt == LAST_BIT);

  // Final magnitude: wrap by default, optionally clamp on add overflow.
  always_comb begin
    w_final_mag = w_mag_shift;
`ifdef SM_ADD_SATURATE_EN
    if (!r_sub && w_cout) begin
      w_final_mag = '1;
    end
`else
`endif
  end

  // Control FSM and datapath; all outputs come straight from registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_sub      <= 1'b0;
      r_res_sign <= 1'b0;
      r_cy       <= 1'b0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_out      <= '0;
      r_carry    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_ready) begin
            r_x        <= w_cap_x;
            r_y        <= w_cap_y;
            r_sub      <= w_sub;
            r_res_sign <= w_cap_sign;
            r_cy       <= 1'b0;
            r_cnt      <= '0;
            r_mag      <= '0;
            r_ready    <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          r_x   <= r_x >> 1;
          r_y   <= r_y >> 1;
          r_cy  <= w_cout;
          r_mag <= w_mag_shift;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_out   <= {r_res_sign, w_final_mag};
            r_carry <= ~r_sub & w_cout;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          if (in_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_out   = r_out;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_sm_serial_adder.sv
// Directed self-checking bench for sm_serial_adder at N=8.
// Expected values are hand-computed sign-magnitude sums; SM_ADD_SATURATE_EN
// selects the clamped expectations for add overflow.
module tb_sm_serial_adder;

  localparam int N = 8;

  logic         in_clk;
  logic         in_rst_n;
  logic         in_valid;
  logic         o_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         o_valid;
  logic         in_ready;
  logic [N-1:0] o_out;
  logic         o_carry;

  int checks;
  int errors;

  sm_serial_adder #(.N(N)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_valid (in_valid),
    .o_ready  (o_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .o_valid  (o_valid),
    .in_ready (in_ready),
    .o_out    (o_out),
    .o_carry  (o_carry)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for o_ready, sampled on the falling edge.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin
      @(negedge in_clk);
      n++;
    end
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  // Count edges after the accept edge until o_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge in_clk);
      lat++;
      @(negedge in_clk);
    end while (o_valid !== 1'b1 && lat < 20);
  endtask

  // Full transaction: accept, latency, result, handshake, ready recovery.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_out, input logic exp_carry);
    int lat;
    wait_ready(tag);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    wait_valid(lat);
    check({tag, "_lat"},   32'(lat),      32'd7);
    check({tag, "_out"},   32'(o_out),    32'(exp_out));
    check({tag, "_carry"}, 32'(o_carry),  32'(exp_carry));
    check({tag, "_busy"},  32'(o_ready),  32'd0);
    in_ready = 1'b1;
    @(posedge in_clk);
    #1;
    in_ready = 1'b0;
    @(negedge in_clk);
    check({tag, "_vdrop"}, 32'(o_valid),  32'd0);
    check({tag, "_rdy"},   32'(o_ready),  32'd1);
    check({tag, "_hold"},  32'(o_out),    32'(exp_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int spurious;
    logic [7:0] exp_ovf;
    logic [7:0] exp_wrap;

    checks   = 0;
    errors   = 0;
    in_rst_n = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_a     = '0;
    in_b     = '0;

`ifdef SM_ADD_SATURATE_EN
    exp_ovf  = 8'h7F;
    exp_wrap = 8'h7F;
`else
    exp_ovf  = 8'h16;
    exp_wrap = 8'h00;
`endif

    // Reset state
    repeat (2) @(negedge in_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_out",   32'(o_out),   32'd0);
    check("rst_carry", 32'(o_carry), 32'd0);
    in_rst_n = 1'b1;
    @(negedge in_clk);

    // Plain add and overflow
    run_op("add_5_3",   8'h05, 8'h03, 8'h08, 1'b0);
    run_op("ovf_100_50", 8'h64, 8'h32, exp_ovf, 1'b1);
    run_op("ovf_127_1", 8'h7F, 8'h01, exp_wrap, 1'b1);

    // Mixed signs
    run_op("mix_5_m3",  8'h05, 8'h83, 8'h02, 1'b0);
    run_op("mix_m5_3",  8'h85, 8'h03, 8'h82, 1'b0);
    run_op("mix_3_m5",  8'h03, 8'h85, 8'h82, 1'b0);
    run_op("mix_m127_1", 8'hFF, 8'h01, 8'hFE, 1'b0);

    // Zero results
    run_op("zero_7_m7", 8'h07, 8'h87, 8'h00, 1'b0);
    run_op("zero_m0_m0", 8'h80, 8'h80, 8'h80, 1'b0);

    // Backpressure with in_valid noise during RUN and DONE
    wait_ready("bp");
    in_a     = 8'h05;
    in_b     = 8'h03;
    in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    in_a = 8'h7F;
    in_b = 8'h7F;
    wait_valid(lat);
    check("bp_lat", 32'(lat),   32'd7);
    check("bp_out", 32'(o_out), 32'h08);
    for (int i = 0; i < 3; i++) begin
      @(negedge in_clk);
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_out",   32'(o_out),   32'h08);
      check("bp_hold_rdy",   32'(o_ready), 32'd0);
    end
    // Keep in_valid high through the handshake edge: it must not be taken there.
    in_a     = 8'h01;
    in_b     = 8'h02;
    in_ready = 1'b1;
    @(posedge in_clk);
    #1;
    in_ready = 1'b0;
    @(negedge in_clk);
    check("bp_rel_valid", 32'(o_valid), 32'd0);
    check("bp_rel_rdy",   32'(o_ready), 32'd1);
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_next_lat", 32'(lat),   32'd7);
    check("bp_next_out", 32'(o_out), 32'h03);
    in_ready = 1'b1;
    @(posedge in_clk);
    #1;
    in_ready = 1'b0;

    // Reset during bit 3 of RUN
    wait_ready("rst_mid");
    in_a     = 8'h05;
    in_b     = 8'h03;
    in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge in_clk);
    #2;
    in_rst_n = 1'b0;
    #1;
    check("rst_mid_out",   32'(o_out),   32'd0);
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    check("rst_mid_carry", 32'(o_carry), 32'd0);
    check("rst_mid_ready", 32'(o_ready), 32'd1);
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge in_clk);
      if (o_valid !== 1'b0) spurious++;
    end
    check("rst_mid_no_valid", 32'(spurious), 32'd0);
    run_op("post_rst_1_1", 8'h01, 8'h01, 8'h02, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
